// File: rtl/weight_buffer_writer.sv
// Packs the byte-wide weight stream into PACK-element words and fills a ping-pong weight buffer,
// one tile per bank. Define WEIGHT_PAD_EN to write a zero-padded partial final word.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module weight_buffer_writer #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int PACK       = 4,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        weight_w_data,
    input  logic                         weight_w_valid,
    input  logic                         weight_w_last,
    output logic                         weight_w_ready,
    output logic                         buf_wr_en,
    output logic                         buf_wr_bank,
    output logic [ADDR_W-1:0]            buf_wr_addr,
    output logic [PACK*DATA_WIDTH-1:0]   buf_wr_data,
    output logic                         tile_valid,
    output logic                         tile_bank,
    output logic [ADDR_W:0]              tile_words,
    input  logic                         tile_release,
    output logic                         overflow
);

    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int WORD_W = PACK * DATA_WIDTH;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

    typedef enum logic {S_FILL, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic                wr_bank_q, wr_bank_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [ADDR_W:0]     addr_q, addr_d, addr_inc;
    logic [WORD_W-1:0]   word_q, word_d, word_new;
    logic [1:0]          full_q, full_d;
    logic [ADDR_W:0]     words_q [2];
    logic [ADDR_W:0]     words_d [2];
    logic                head_q, head_d;
    logic                overflow_q, overflow_d;
    logic                buf_wr_en_q, buf_wr_en_d;
    logic                buf_wr_bank_q, buf_wr_bank_d;
    logic [ADDR_W-1:0]   buf_wr_addr_q, buf_wr_addr_d;
    logic [WORD_W-1:0]   buf_wr_data_q, buf_wr_data_d;
    logic                tile_valid_q, tile_valid_d;
    logic                tile_bank_q, tile_bank_d;
    logic [ADDR_W:0]     tile_words_q, tile_words_d;

    logic accept, end_word, issue, do_write, rel;

    always_comb begin
        accept   = weight_w_valid && (state_q == S_FILL);
        end_word = (lane_q == LAST_LANE);
        word_new = word_q;
        word_new[lane_q*DATA_WIDTH +: DATA_WIDTH] = weight_w_data;
`ifdef WEIGHT_PAD_EN
        issue    = accept && (end_word || weight_w_last);
`else
        issue    = accept && end_word;
`endif
        // Words beyond the bank are dropped but still flag overflow.
        do_write = issue && (addr_q != DEPTH_C);
        rel      = tile_release && tile_valid_q;
        addr_inc = addr_q + {{ADDR_W{1'b0}}, do_write};

        state_d    = state_q;
        wr_bank_d  = wr_bank_q;
        lane_d     = lane_q;
        addr_d     = addr_inc;
        word_d     = word_q;
        full_d     = full_q;
        words_d    = words_q;
        head_d     = head_q;
        overflow_d = overflow_q | (issue && (addr_q == DEPTH_C));

        if (accept) begin
            if (end_word || weight_w_last) begin
                lane_d = '0;
                word_d = '0;
            end else begin
                lane_d = lane_q + LANE_W'(1);
                word_d = word_new;
            end
        end

        // Release frees the head tile; it never targets the bank being filled.
        if (rel) begin
            full_d[tile_bank_q] = 1'b0;
            head_d              = ~tile_bank_q;
        end

        if (accept && weight_w_last) begin
            full_d[wr_bank_q]  = 1'b1;
            words_d[wr_bank_q] = addr_inc;
            wr_bank_d          = ~wr_bank_q;
            addr_d             = '0;
        end

        case (state_q)
            S_FILL: if (accept && weight_w_last && full_d[~wr_bank_q]) state_d = S_WAIT;
            S_WAIT: if (!full_d[wr_bank_q]) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase

        buf_wr_en_d   = do_write;
        buf_wr_bank_d = do_write ? wr_bank_q : 1'b0;
        buf_wr_addr_d = do_write ? addr_q[ADDR_W-1:0] : '0;
        buf_wr_data_d = do_write ? word_new : '0;

        tile_valid_d = |full_q;
        tile_bank_d  = (|full_q) ? head_q : 1'b0;
        tile_words_d = (|full_q) ? words_q[head_q] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FILL;
            wr_bank_q     <= 1'b0;
            lane_q        <= '0;
            addr_q        <= '0;
            word_q        <= '0;
            full_q        <= '0;
            words_q[0]    <= '0;
            words_q[1]    <= '0;
            head_q        <= 1'b0;
            overflow_q    <= 1'b0;
            buf_wr_en_q   <= 1'b0;
            buf_wr_bank_q <= 1'b0;
            buf_wr_addr_q <= '0;
            buf_wr_data_q <= '0;
            tile_valid_q  <= 1'b0;
            tile_bank_q   <= 1'b0;
            tile_words_q  <= '0;
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            lane_q        <= lane_d;
            addr_q        <= addr_d;
            word_q        <= word_d;
            full_q        <= full_d;
            words_q       <= words_d;
            head_q        <= head_d;
            overflow_q    <= overflow_d;
            buf_wr_en_q   <= buf_wr_en_d;
            buf_wr_bank_q <= buf_wr_bank_d;
            buf_wr_addr_q <= buf_wr_addr_d;
            buf_wr_data_q <= buf_wr_data_d;
            tile_valid_q  <= tile_valid_d;
            tile_bank_q   <= tile_bank_d;
            tile_words_q  <= tile_words_d;
        end
    end

    assign weight_w_ready = (state_q == S_FILL) && !rst;
    assign buf_wr_en      = buf_wr_en_q;
    assign buf_wr_bank    = buf_wr_bank_q;
    assign buf_wr_addr    = buf_wr_addr_q;
    assign buf_wr_data    = buf_wr_data_q;
    assign tile_valid     = tile_valid_q;
    assign tile_bank      = tile_bank_q;
    assign tile_words     = tile_words_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_weight_buffer_writer.sv
// Bench for weight_buffer_writer: directed tile scenarios plus random streams, scored against
// a tile-level model (element queue, bank FULL flags, completion-order queue).
module tb_weight_buffer_writer;

    localparam int DW = `DATA_WIDTH;
    localparam int PK = 4;
    localparam int DP = 16;
    localparam int AW = 4;
`ifdef WEIGHT_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW-1:0]     weight_w_data = '0;
    logic              weight_w_valid = 1'b0;
    logic              weight_w_last = 1'b0;
    logic              weight_w_ready;
    logic              buf_wr_en;
    logic              buf_wr_bank;
    logic [AW-1:0]     buf_wr_addr;
    logic [PK*DW-1:0]  buf_wr_data;
    logic              tile_valid;
    logic              tile_bank;
    logic [AW:0]       tile_words;
    logic              tile_release = 1'b0;
    logic              overflow;

    int checks = 0;
    int failures = 0;

    weight_buffer_writer #(.DATA_WIDTH(DW), .PACK(PK), .DEPTH(DP), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .weight_w_data(weight_w_data), .weight_w_valid(weight_w_valid),
        .weight_w_last(weight_w_last), .weight_w_ready(weight_w_ready),
        .buf_wr_en(buf_wr_en), .buf_wr_bank(buf_wr_bank), .buf_wr_addr(buf_wr_addr),
        .buf_wr_data(buf_wr_data), .tile_valid(tile_valid), .tile_bank(tile_bank),
        .tile_words(tile_words), .tile_release(tile_release), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_full [2] = '{1'b0, 1'b0};
    int          m_words [2] = '{0, 0};
    bit          m_wr_bank = 1'b0;
    bit          m_ovf = 1'b0;
    int          m_order [$];
    logic [DW-1:0] m_elems [$];
    bit          e_wr_en = 1'b0;
    bit          e_wr_bank = 1'b0;
    int          e_wr_addr = 0;
    logic [PK*DW-1:0] e_wr_data = '0;
    bit          e_tv = 1'b0;
    bit          e_tb = 1'b0;
    int          e_tw = 0;
    int          n, w, nw, fb, nxt_tw;
    bit          rdy_m, nxt_tv, nxt_tb;

    function automatic logic [PK*DW-1:0] pack_word(input int wi);
        logic [PK*DW-1:0] r;
        r = '0;
        for (int k = 0; k < PK; k++)
            if (wi*PK + k < m_elems.size()) r[k*DW +: DW] = m_elems[wi*PK + k];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_full = '{1'b0, 1'b0};
            m_words = '{0, 0};
            m_wr_bank = 1'b0;
            m_ovf = 1'b0;
            m_order.delete();
            m_elems.delete();
            e_wr_en = 1'b0; e_wr_bank = 1'b0; e_wr_addr = 0; e_wr_data = '0;
            e_tv = 1'b0; e_tb = 1'b0; e_tw = 0;
        end else begin
            rdy_m  = !m_full[m_wr_bank];
            nxt_tv = (m_order.size() != 0);
            nxt_tb = nxt_tv ? m_order[0][0] : 1'b0;
            nxt_tw = nxt_tv ? m_words[m_order[0]] : 0;
            e_wr_en = 1'b0; e_wr_bank = 1'b0; e_wr_addr = 0; e_wr_data = '0;
            if (tile_release && e_tv) begin
                fb = m_order.pop_front();
                m_full[fb] = 1'b0;
            end
            if (weight_w_valid && rdy_m) begin
                m_elems.push_back(weight_w_data);
                n = m_elems.size();
                w = -1;
                if (n % PK == 0) w = n / PK - 1;
                else if (weight_w_last && PAD) w = n / PK;
                if (w >= 0) begin
                    if (w < DP) begin
                        e_wr_en = 1'b1;
                        e_wr_bank = m_wr_bank;
                        e_wr_addr = w;
                        e_wr_data = pack_word(w);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (weight_w_last) begin
                    nw = PAD ? (n + PK - 1) / PK : n / PK;
                    m_words[m_wr_bank] = (nw > DP) ? DP : nw;
                    m_full[m_wr_bank] = 1'b1;
                    m_order.push_back(int'(m_wr_bank));
                    m_wr_bank = ~m_wr_bank;
                    m_elems.delete();
                end
            end
            e_tv = nxt_tv; e_tb = nxt_tb; e_tw = nxt_tw;
        end
    end

    always @(negedge clk) begin
        chk("ready", 64'(weight_w_ready), 64'(!rst && !m_full[m_wr_bank]));
        chk("wr_en", 64'(buf_wr_en), 64'(e_wr_en));
        if (e_wr_en) begin
            chk("wr_bank", 64'(buf_wr_bank), 64'(e_wr_bank));
            chk("wr_addr", 64'(buf_wr_addr), 64'(e_wr_addr));
            chk("wr_data", 64'(buf_wr_data), 64'(e_wr_data));
        end
        chk("tile_valid", 64'(tile_valid), 64'(e_tv));
        if (e_tv) begin
            chk("tile_bank", 64'(tile_bank), 64'(e_tb));
            chk("tile_words", 64'(tile_words), 64'(e_tw));
        end
        chk("overflow", 64'(overflow), 64'(m_ovf));
    end

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk); #1;
            weight_w_valid = 1'b0; weight_w_last = 1'b0; tile_release = 1'b0;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l, input logic r);
        int waited;
        waited = 0;
        @(negedge clk); #1;
        weight_w_valid = 1'b1; weight_w_data = d; weight_w_last = l; tile_release = r;
        while (!weight_w_ready && waited < 200) begin
            @(negedge clk); #1;
            waited++;
        end
        if (waited >= 200) chk("send_timeout", 64'(weight_w_ready), 64'd1);
    endtask

    task automatic pulse_release();
        @(negedge clk); #1;
        weight_w_valid = 1'b0; weight_w_last = 1'b0; tile_release = 1'b1;
        idle(3);
    endtask

    task automatic reset_pulse();
        @(negedge clk); #1;
        weight_w_valid = 1'b0; weight_w_last = 1'b0; tile_release = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(weight_w_ready), 64'd0);
        chk("rst_tile_valid", 64'(tile_valid), 64'd0);
        chk("rst_wr_en", 64'(buf_wr_en), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        #1 rst = 1'b0;
    endtask

    task automatic random_phase(input int cycles, input int last_mod);
        int gap;
        gap = 10;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk); #1;
            weight_w_valid = ($urandom_range(3) != 0);
            weight_w_data  = DW'($urandom);
            weight_w_last  = ($urandom_range(last_mod - 1) == 0);
            gap++;
            if (gap > 2 && $urandom_range(5) == 0) begin
                tile_release = 1'b1;
                gap = 0;
            end else begin
                tile_release = 1'b0;
            end
        end
        idle(3);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_pulse();
        idle(1);

        // 0x01..0x08 -> two words in bank0
        for (int i = 1; i <= 8; i++) send(DW'(i), i == 8, 1'b0);
        idle(1);
        @(negedge clk);
        chk("t1_tile_valid", 64'(tile_valid), 64'd1);
        chk("t1_tile_bank", 64'(tile_bank), 64'd0);
        chk("t1_tile_words", 64'(tile_words), 64'd2);
        pulse_release();

        // six elements: partial final word
        for (int i = 1; i <= 6; i++) send(DW'(8'hA0 + i), i == 6, 1'b0);
        idle(1);
        @(negedge clk);
        chk("t2_tile_bank", 64'(tile_bank), 64'd1);
        chk("t2_tile_words", 64'(tile_words), PAD ? 64'd2 : 64'd1);
        pulse_release();

        // two full tiles, no release -> back-pressure
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < 8; i++) send(DW'(16*t + i), i == 7, 1'b0);
        idle(1);
        @(negedge clk);
        chk("t3_ready_low", 64'(weight_w_ready), 64'd0);
        #1 tile_release = 1'b1;
        @(negedge clk);
        chk("t3_ready_after_rel", 64'(weight_w_ready), 64'd1);
        #1 tile_release = 1'b0;
        @(negedge clk);
        chk("t3_tile_bank", 64'(tile_bank), 64'd1);
        idle(2);
        for (int i = 0; i < 8; i++) send(DW'(8'h50 + i), i == 7, 1'b0);
        idle(2);
        pulse_release();

        // completion into bank1 while releasing bank0 in the same cycle
        for (int i = 0; i < 8; i++) send(DW'(8'h60 + i), i == 7, i == 7);
        idle(1);
        @(negedge clk);
        chk("t5_tile_valid", 64'(tile_valid), 64'd1);
        chk("t5_tile_bank", 64'(tile_bank), 64'd1);
        chk("t5_ready", 64'(weight_w_ready), 64'd1);
        idle(2);

        // reset mid-tile, then the next element starts bank0 addr0 lane0
        for (int i = 0; i < 3; i++) send(DW'(8'h70 + i), 1'b0, 1'b0);
        reset_pulse();
        for (int i = 0; i < 8; i++) send(DW'(8'h11 + i), i == 7, 1'b0);
        idle(2);

        // overflow: 70 elements into a 16-word bank
        reset_pulse();
        for (int i = 0; i < 70; i++) begin
            send(DW'(i), i == 69, 1'b0);
            chk("ovf_ready", 64'(weight_w_ready), 64'd1);
        end
        idle(1);
        @(negedge clk);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_tile_words", 64'(tile_words), 64'(DP));
        idle(2);

        reset_pulse();
        random_phase(3000, 12);
        random_phase(1500, 90);
        reset_pulse();
        random_phase(1000, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
